// File: rtl/plc_tx_frame_scheduler.sv
// rtl/plc_tx_frame_scheduler.sv - round-robin framer sharing the serializer FIFO among byte sources
module plc_tx_frame_scheduler #(
  parameter int         N_SRC     = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         GAP_CYC   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   src_req,
  input  logic [4*N_SRC-1:0] src_len,
  input  logic [8*N_SRC-1:0] src_data,
  output logic [N_SRC-1:0]   src_rd,
  output logic [N_SRC-1:0]   src_ack,
  output logic [N_SRC-1:0]   grant,
  input  logic               fifo_full,
  output logic               wr_fifo,
  output logic [7:0]         wr_data,
  input  logic               piso_done,
  output logic               busy
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int GW = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_HDR, S_PAY, S_CHK, S_DRAIN, S_GAP
  } state_t;

  state_t state, state_nx;

  logic [3:0]       rr_ptr, win_id, len_q, byte_cnt;
  logic [4:0]       done_cnt;
  logic [7:0]       chk;
  logic [GW-1:0]    gap_cnt;
  logic [N_SRC-1:0] grant_q;

  logic             arb_found;
  logic [3:0]       arb_id, arb_len;
  logic [4:0]       cand;
  logic [N_SRC-1:0] arb_onehot, win_onehot;
  logic [7:0]       pay_byte, hdr;
  logic             last_pay, drain_done, gap_last, counting;

  // Search starts one past the last winner and wraps, so every requester is reached within N_SRC steps.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = rr_ptr;
    cand      = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = 5'(rr_ptr) + 5'(k);
      if (cand >= 5'(N_SRC)) cand = cand - 5'(N_SRC);
      if (!arb_found && src_req[cand[IW-1:0]]) begin
        arb_found = 1'b1;
        arb_id    = 4'(cand);
      end
    end
  end

  always_comb begin
    pay_byte   = '0;
    arb_len    = '0;
    arb_onehot = '0;
    win_onehot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      arb_onehot[i] = (arb_id == 4'(i));
      win_onehot[i] = (win_id == 4'(i));
      if (win_id == 4'(i)) pay_byte = src_data[8*i +: 8];
      if (arb_id == 4'(i)) arb_len = src_len[4*i +: 4];
    end
  end

  assign hdr        = {win_id, len_q};
  assign last_pay   = (byte_cnt == len_q - 4'd1);
  assign drain_done = (done_cnt >= 5'(len_q) + 5'd3);
  assign gap_last   = (gap_cnt == GW'(GAP_CYC - 1));
  assign counting   = (state != S_IDLE) && (state != S_GAP);
  assign busy       = (state != S_IDLE);
  assign grant      = grant_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wr_fifo  = 1'b0;
    wr_data  = '0;
    src_rd   = '0;
    src_ack  = '0;
    case (state)
      S_IDLE: if (arb_found) state_nx = S_SYNC;
      S_SYNC: begin
        wr_fifo = !fifo_full;
        wr_data = SYNC_BYTE;
        if (wr_fifo) state_nx = S_HDR;
      end
      S_HDR: begin
        wr_fifo = !fifo_full;
        wr_data = hdr;
        if (wr_fifo) state_nx = (len_q == 4'd0) ? S_CHK : S_PAY;
      end
      S_PAY: begin
        wr_fifo = !fifo_full;
        wr_data = pay_byte;
        src_rd  = wr_fifo ? win_onehot : '0;
        if (wr_fifo && last_pay) state_nx = S_CHK;
      end
      S_CHK: begin
        wr_fifo = !fifo_full;
        wr_data = chk;
        if (wr_fifo) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_done) begin
          src_ack  = grant_q;
          state_nx = S_GAP;
        end
      end
      S_GAP:   if (gap_last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= 4'(N_SRC - 1);
      win_id   <= '0;
      len_q    <= '0;
      byte_cnt <= '0;
      done_cnt <= '0;
      chk      <= '0;
      gap_cnt  <= '0;
      grant_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_found) begin
            grant_q  <= arb_onehot;
            win_id   <= arb_id;
            rr_ptr   <= arb_id;
            len_q    <= arb_len;
            chk      <= '0;
            done_cnt <= '0;
            byte_cnt <= '0;
          end
        end
        S_HDR: if (wr_fifo) chk <= hdr;
        S_PAY: begin
          if (wr_fifo) begin
            chk      <= chk ^ pay_byte;
            byte_cnt <= byte_cnt + 4'd1;
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            grant_q <= '0;
            gap_cnt <= '0;
          end
        end
        S_GAP:   gap_cnt <= gap_cnt + GW'(1);
        default: ;
      endcase
      // Serializer may shift bytes out while later bytes of the same frame are still being written.
      if (counting && piso_done && done_cnt != 5'h1F) done_cnt <= done_cnt + 5'd1;
    end
  end

endmodule

// File: tb/tb_plc_tx_frame_scheduler.sv
// tb/tb_plc_tx_frame_scheduler.sv - scoreboard bench for plc_tx_frame_scheduler
module tb_plc_tx_frame_scheduler;

  localparam int N   = 4;
  localparam int GAP = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   src_req;
  logic [4*N-1:0] src_len;
  logic [8*N-1:0] src_data;
  logic [N-1:0]   src_rd, src_ack, grant;
  logic           fifo_full, wr_fifo;
  logic [7:0]     wr_data;
  logic           piso_done, busy;

  plc_tx_frame_scheduler #(.N_SRC(N), .SYNC_BYTE(8'hA5), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst), .src_req(src_req), .src_len(src_len), .src_data(src_data),
    .src_rd(src_rd), .src_ack(src_ack), .grant(grant), .fifo_full(fifo_full),
    .wr_fifo(wr_fifo), .wr_data(wr_data), .piso_done(piso_done), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] pay [N][16];
  int         plen [N];
  int         pptr [N];
  logic [7:0] exp_q [N][$];
  int         errors = 0;
  int         checks = 0;
  int         pending = 0;
  logic [N-1:0] rd_s, ack_s;
  logic         wr_s, pd_s;

  int  cur = -1, rr_m = N - 1, wrc = 0, pulses = 0, mlen = 0, cycle = 0, ack_cyc = -1000, m_w;
  bit  gap_exact = 0;
  logic [N-1:0] req_prev = '0, exp_ack;
  logic         rst_prev = 1'b0, exp_wr;
  logic [7:0]   exp_b;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      src_data[8*i +: 8] = pay[i][pptr[i]];
      src_len[4*i +: 4]  = plen[i][3:0];
    end
  end

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0 && i < N) v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: reference model of arbitration, frame content and drain/gap timing.
  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      if (rst_prev) begin
        check("rst_grant", grant, 0);
        check("rst_wr", {wr_fifo, src_rd, src_ack}, 0);
        check("rst_busy", busy, 0);
        check("rst_wdata", wr_data, 0);
      end
      cur = -1; rr_m = N - 1; ack_cyc = -1000; gap_exact = 0;
    end else begin
      if (cur < 0 && grant != 0) begin
        m_w = -1;
        for (int k = 1; k <= N; k++)
          if (m_w < 0 && req_prev[(rr_m + k) % N]) m_w = (rr_m + k) % N;
        check("grant_pick", grant, oh(m_w));
        if (gap_exact) check("gap_len", cycle - ack_cyc, GAP + 2);
        gap_exact = 0;
        if (m_w >= 0) begin
          cur = m_w; rr_m = m_w; wrc = 0; pulses = 0; mlen = plen[m_w];
        end
      end
      if (cur >= 0) begin
        exp_ack = (pulses == mlen + 3 && wrc == mlen + 3) ? oh(cur) : '0;
        exp_wr  = (wrc < mlen + 3) && !fifo_full;
        check("grant_hold", grant, oh(cur));
        check("busy_frame", busy, 1);
        check("write_rule", wr_fifo, exp_wr);
        check("src_rd", src_rd, (exp_wr && wrc >= 2 && wrc <= mlen + 1) ? oh(cur) : '0);
        if (wr_fifo) begin
          if (exp_q[cur].size() > 0) begin
            exp_b = exp_q[cur].pop_front();
            check("wr_data", wr_data, exp_b);
          end
          wrc++;
        end
        check("src_ack", src_ack, exp_ack);
        if (piso_done) pulses++;
        if (exp_ack != 0) begin
          gap_exact = (src_req & ~oh(cur)) != 0;
          cur = -1;
          ack_cyc = cycle;
        end
      end else if (grant == 0) begin
        check("busy_idle", busy, (cycle - ack_cyc) <= GAP);
        check("idle_quiet", {wr_fifo, src_rd, src_ack}, 0);
      end
    end
    req_prev = src_req;
    rst_prev = rst;
  end

  // One clock of source and serializer behaviour.
  task automatic step(input int ff_pct, input int pd_pct, input bit force_full);
    @(negedge clk);
    rd_s = src_rd; ack_s = src_ack; wr_s = wr_fifo; pd_s = piso_done;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rd_s[i]) pptr[i]++;
      if (ack_s[i]) src_req[i] = 1'b0;
    end
    pending = pending + int'(wr_s) - int'(pd_s);
    piso_done = (pending > 0) && ($urandom_range(99) < pd_pct);
    fifo_full = force_full || ($urandom_range(99) < ff_pct);
  endtask

  task automatic load(input int i, input int len);
    plen[i] = len;
    pptr[i] = 0;
    for (int k = 0; k < 16; k++) pay[i][k] = 8'($urandom);
  endtask

  task automatic push_exp(input int i);
    logic [7:0] h, c;
    h = {4'(i), 4'(plen[i])};
    exp_q[i].delete();
    exp_q[i].push_back(8'hA5);
    exp_q[i].push_back(h);
    c = h;
    for (int k = 0; k < plen[i]; k++) begin
      exp_q[i].push_back(pay[i][k]);
      c = c ^ pay[i][k];
    end
    exp_q[i].push_back(c);
    src_req[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; src_req = '0; fifo_full = 1'b0; piso_done = 1'b0;
    repeat (3) step(0, 0, 0);
    for (int i = 0; i < N; i++) begin
      pptr[i] = 0;
      exp_q[i].delete();
    end
    pending = 0; piso_done = 1'b0; fifo_full = 1'b0;
    rst = 1'b0;
  endtask

  task automatic run_idle(input int ff, input int pd, input int budget);
    int n;
    n = 0;
    do begin
      step(ff, pd, 0);
      n++;
    end while (!(src_req == 0 && !busy && pending == 0) && n < budget);
    check("phase_done", {busy, src_req}, 0);
  endtask

  initial begin
    int n;
    bit again;
    rst = 1'b1; src_req = '0; fifo_full = 1'b0; piso_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      plen[i] = 0; pptr[i] = 0;
      for (int k = 0; k < 16; k++) pay[i][k] = '0;
    end
    do_reset();

    // Single frame with known bytes: A5 03 11 22 33 03
    load(0, 3);
    pay[0][0] = 8'h11; pay[0][1] = 8'h22; pay[0][2] = 8'h33;
    push_exp(0);
    run_idle(0, 30, 300);

    // All sources request, source 0 re-requests after its first frame
    do_reset();
    for (int i = 0; i < N; i++) begin
      load(i, 1);
      push_exp(i);
    end
    again = 0; n = 0;
    do begin
      step(0, 50, 0);
      n++;
      if (ack_s[0] && !again) begin
        again = 1;
        load(0, 1);
        push_exp(0);
      end
    end while (!(again && src_req == 0 && !busy && pending == 0) && n < 600);
    check("rr_phase_done", {busy, src_req}, 0);

    // Five cycles of fifo_full right after the first payload byte
    load(0, 6); push_exp(0);
    n = 0;
    do begin
      step(0, 40, 0);
      n++;
    end while (!rd_s[0] && n < 100);
    fifo_full = 1'b1;
    repeat (4) step(0, 40, 1);
    run_idle(0, 40, 300);

    // Empty payload: A5 20 20
    load(2, 0); push_exp(2);
    run_idle(0, 50, 300);

    // Reset during the payload of a long frame with other requests pending
    load(1, 10); push_exp(1);
    n = 0;
    do begin
      step(0, 30, 0);
      n++;
    end while (pptr[1] < 3 && n < 100);
    load(0, 2); push_exp(0);
    load(2, 4); push_exp(2);
    step(0, 30, 0);
    rst = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < N; i++)
      if (src_req[i]) begin
        pptr[i] = 0;
        push_exp(i);
      end
    pending = 0; piso_done = 1'b0; fifo_full = 1'b0;
    rst = 1'b0;
    run_idle(0, 40, 600);

    // Random traffic with FIFO back-pressure and concurrent serializer draining
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (!src_req[i] && $urandom_range(99) < 8) begin
          load(i, $urandom_range(15));
          push_exp(i);
        end
      step(20, 40, 0);
    end
    run_idle(20, 40, 3000);

    n = 0;
    for (int i = 0; i < N; i++) n += exp_q[i].size();
    check("queues_drained", n, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
